button_cmd_reader: RTL and testbench
====================================

Name: button_cmd_reader

Overview:
- Input-side counterpart of the board LED bar display: reads the user push-buttons and turns them into a signed 16-bit command value for the control datapath.
- Per-button chain: raw active-low button, 2-FF synchroniser, counter debouncer, hold-to-repeat state machine, saturating up/down accumulator.
- Output `cmd_out` uses the same signed 16-bit format as the motor-drive values shown on the LEDs.

Parameters:
- DB_CNT, 1000000: clocks a synchronised input must stay stable before the debounced level changes (20 ms at 50 MHz).
- REP_DLY, 25000000: clocks a button must be held after the first step before auto-repeat starts.
- REP_PER, 5000000: clocks between auto-repeat steps.
- STEP, 16'sh0100: magnitude added or subtracted per step.
- LIMIT, 16'sh7F00: saturation bound; `cmd_out` is clamped to the range −LIMIT to +LIMIT.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-low
- btn_up_n  input  1  raw "up" button, active-low, asynchronous to clk
- btn_dn_n  input  1  raw "down" button, active-low, asynchronous
- btn_zero_n  input  1  raw "zero" button, active-low, asynchronous
- cmd_out  output  16  signed command value
- cmd_vld  output  1  one-clock pulse when cmd_out changes
- up_held  output  1  debounced "up" pressed level
- dn_held  output  1  debounced "down" pressed level

Behaviour:
- Reset: clk and rst_n only; reset is asynchronous, active-low. On reset:
  - synchroniser flops = 1 (released);
  - debounce counters = 0 and stable levels = released;
  - repeat FSMs = IDLE and repeat timers = 0;
  - cmd_out = 0, cmd_vld = 0, up_held = 0, dn_held = 0.
- Synchroniser: each button passes through two flops before any logic uses it.
- Debounce, per button:
  - sync ≠ stable: counter increments.
  - sync = stable: counter clears to 0.
  - Counter reaches DB_CNT−1 with sync still ≠ stable: stable takes sync and the counter clears.
  - A glitch shorter than DB_CNT clocks never changes stable.
- Latency: a clean raw press asserts up_held/dn_held DB_CNT+2 clocks after the raw edge is first sampled. The resulting cmd_out update appears 1 clock later.
- Repeat FSM, up and down buttons each:
  - IDLE → FIRST on the debounced press edge; emits one step event.
  - FIRST: timer counts to REP_DLY−1, then go to RPT and emit a step event.
  - RPT: emit a step event every REP_PER clocks.
  - Any state → IDLE on debounced release; timer clears, no step on release.
- Zero button: its debounced press edge produces a zero event. It has no repeat behaviour.
- Accumulator update, priority order:
  1. zero event: cmd_out ← 0.
  2. up and down step events in the same clock: no change.
  3. up step: cmd_out ← min(cmd_out+STEP, LIMIT).
  4. down step: cmd_out ← max(cmd_out−STEP, −LIMIT).
- Width rules: compute in 17 bits signed, then clamp. Wrap-around is never allowed.
- cmd_vld: high for exactly the one clock in which cmd_out takes a new value.
  - A step while already at ±LIMIT gives no pulse.
  - Zero while already at 0 gives no pulse.
- Both up and down held: each FSM runs independently; coincident steps cancel per the rule above.
- Reset mid-hold: everything returns to reset values. After rst_n deasserts, a button still held is treated as a fresh press once debounced.

Test Plan (sim overrides DB_CNT=4, REP_DLY=20, REP_PER=5, STEP=16'sh0100, LIMIT=16'sh0300):
- Reset, then hold btn_up_n low for 10 clocks and release → up_held rises at clk 6. cmd_out=16'sh0100 with a one-clock cmd_vld at clk 7. No further change.
- Glitch btn_dn_n low for 3 clocks → dn_held stays 0, cmd_out stays 0, cmd_vld never asserts.
- Hold btn_up_n 60 clocks → steps at 7, 27, 32, 37. cmd_out goes 0x0100, 0x0200, 0x0300, then holds 0x0300 with no cmd_vld for the saturated step at 37.
- From 0x0300, tap btn_dn_n 4 times (each 10 low / 10 high) → 0x0200, 0x0100, 0x0000, 0xFF00, one cmd_vld each.
- cmd_out=0x0200, press btn_zero_n while btn_up_n is held → cmd_out=0 on the zero event. Up repeats resume from 0 afterwards.
- Assert rst_n low mid-repeat with cmd_out=0x0200 → cmd_out=0 and FSMs IDLE immediately. With up still held after release, first step arrives 7 clocks later.

Source files
------------

// File: rtl/button_cmd_reader_if.sv
// Push-button inputs and signed command outputs of the button command reader.
// The bench or board side uses master; the reader uses slave.
interface button_cmd_reader_if;
  logic               btn_up_n;
  logic               btn_dn_n;
  logic               btn_zero_n;
  logic signed [15:0] cmd_out;
  logic               cmd_vld;
  logic               up_held;
  logic               dn_held;

  modport master (
    output btn_up_n, btn_dn_n, btn_zero_n,
    input  cmd_out, cmd_vld, up_held, dn_held
  );

  modport slave (
    input  btn_up_n, btn_dn_n, btn_zero_n,
    output cmd_out, cmd_vld, up_held, dn_held
  );
endinterface

// File: rtl/button_cmd_reader.sv
// Push-buttons to signed 16-bit command: sync, debounce, hold-to-repeat and a
// saturating accumulator. One debounce lane per button, one repeat lane per direction.

module btn_debounce #(
  parameter int DB_CNT = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_n,
  output logic pressed
);
  localparam int DBW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;

  logic [1:0]     sync;
  logic [DBW-1:0] cnt;
  logic           lvl;

  assign lvl = ~sync[1];

  // pressed only follows lvl after DB_CNT consecutive clocks of disagreement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= 2'b11;
      cnt     <= '0;
      pressed <= 1'b0;
    end else begin
      sync <= {sync[0], raw_n};
      if (lvl == pressed) begin
        cnt <= '0;
      end else if (cnt == DBW'(DB_CNT - 1)) begin
        pressed <= lvl;
        cnt     <= '0;
      end else begin
        cnt <= cnt + DBW'(1);
      end
    end
  end
endmodule

module btn_repeat #(
  parameter int REP_DLY = 25000000,
  parameter int REP_PER = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pressed,
  output logic step
);
  localparam int TMAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [1:0] {IDLE, FIRST, RPT} state_t;

  state_t        state;
  logic [TW-1:0] tmr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tmr   <= '0;
      step  <= 1'b0;
    end else begin
      step <= 1'b0;
      case (state)
        IDLE: begin
          tmr <= '0;
          if (pressed) begin
            state <= FIRST;
            step  <= 1'b1;
          end
        end
        FIRST: begin
          if (!pressed) begin
            state <= IDLE;
            tmr   <= '0;
          end else if (tmr == TW'(REP_DLY - 1)) begin
            state <= RPT;
            tmr   <= '0;
            step  <= 1'b1;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        RPT: begin
          if (!pressed) begin
            state <= IDLE;
            tmr   <= '0;
          end else if (tmr == TW'(REP_PER - 1)) begin
            tmr  <= '0;
            step <= 1'b1;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tmr   <= '0;
        end
      endcase
    end
  end
endmodule

module button_cmd_reader #(
  parameter int                 DB_CNT  = 1000000,
  parameter int                 REP_DLY = 25000000,
  parameter int                 REP_PER = 5000000,
  parameter logic signed [15:0] STEP    = 16'sh0100,
  parameter logic signed [15:0] LIMIT   = 16'sh7F00
) (
  input logic                 clk,
  input logic                 rst_n,
  button_cmd_reader_if.slave  bus
);
  localparam int NUM_BTN = 3;   // lane 0 up, 1 down, 2 zero
  localparam int NUM_RPT = 2;
  localparam logic signed [16:0] LIM_P  = {LIMIT[15], LIMIT};
  localparam logic signed [16:0] LIM_N  = -LIM_P;
  localparam logic signed [16:0] STEP17 = {STEP[15], STEP};

  logic [NUM_BTN-1:0] raw_n;
  logic [NUM_BTN-1:0] pressed;
  logic [NUM_RPT-1:0] step;

  assign raw_n = {bus.btn_zero_n, bus.btn_dn_n, bus.btn_up_n};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    btn_debounce #(.DB_CNT(DB_CNT)) u_db (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw_n   (raw_n[i]),
      .pressed (pressed[i])
    );
  end

  for (genvar i = 0; i < NUM_RPT; i++) begin : g_rep
    btn_repeat #(.REP_DLY(REP_DLY), .REP_PER(REP_PER)) u_rep (
      .clk     (clk),
      .rst_n   (rst_n),
      .pressed (pressed[i]),
      .step    (step[i])
    );
  end

  // Zero is registered like the step events so all three share the same latency
  logic zero_prev, zero_ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_prev <= 1'b0;
      zero_ev   <= 1'b0;
    end else begin
      zero_prev <= pressed[2];
      zero_ev   <= pressed[2] & ~zero_prev;
    end
  end

  logic signed [15:0] cmd_q, cmd_nxt;
  logic signed [16:0] sum_up, sum_dn;
  logic               vld_q, up_q, dn_q;

  // 17-bit arithmetic keeps the pre-clamp value from wrapping
  always_comb begin
    sum_up  = {cmd_q[15], cmd_q} + STEP17;
    sum_dn  = {cmd_q[15], cmd_q} - STEP17;
    cmd_nxt = cmd_q;
    if (zero_ev)
      cmd_nxt = '0;
    else if (step[0] && step[1])
      cmd_nxt = cmd_q;
    else if (step[0])
      cmd_nxt = (sum_up > LIM_P) ? LIM_P[15:0] : sum_up[15:0];
    else if (step[1])
      cmd_nxt = (sum_dn < LIM_N) ? LIM_N[15:0] : sum_dn[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q <= '0;
      vld_q <= 1'b0;
      up_q  <= 1'b0;
      dn_q  <= 1'b0;
    end else begin
      cmd_q <= cmd_nxt;
      vld_q <= (cmd_nxt != cmd_q);
      up_q  <= pressed[0];
      dn_q  <= pressed[1];
    end
  end

  assign bus.cmd_out = cmd_q;
  assign bus.cmd_vld = vld_q;
  assign bus.up_held = up_q;
  assign bus.dn_held = dn_q;
endmodule

// File: tb/tb_button_cmd_reader.sv
// Directed bench for button_cmd_reader with short debounce/repeat timing.
// Cycle index c counts posedges from the first one that samples a new button level.
module tb_button_cmd_reader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  button_cmd_reader_if bus();

  button_cmd_reader #(
    .DB_CNT(4), .REP_DLY(20), .REP_PER(5),
    .STEP(16'sh0100), .LIMIT(16'sh0300)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.btn_up_n = 1'b1;
    bus.btn_dn_n = 1'b1;
    bus.btn_zero_n = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.btn_up_n = 1'b1;
    bus.btn_dn_n = 1'b1;
    bus.btn_zero_n = 1'b1;
    #2;
    n_total++; if (bus.cmd_out !== 16'h0000) $display("FAIL reset_cmd got=%h exp=0000", bus.cmd_out); else n_pass++;
    n_total++; if (bus.cmd_vld !== 1'b0) $display("FAIL reset_vld got=%b exp=0", bus.cmd_vld); else n_pass++;
    n_total++; if (bus.up_held !== 1'b0) $display("FAIL reset_up_held got=%b exp=0", bus.up_held); else n_pass++;
    n_total++; if (bus.dn_held !== 1'b0) $display("FAIL reset_dn_held got=%b exp=0", bus.dn_held); else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    n_total++; if (bus.cmd_out !== 16'h0000) $display("FAIL idle_cmd got=%h exp=0000", bus.cmd_out); else n_pass++;
    n_total++; if (bus.cmd_vld !== 1'b0) $display("FAIL idle_vld got=%b exp=0", bus.cmd_vld); else n_pass++;
  endtask

  task automatic test_single_press();
    logic [15:0] exp_cmd;
    do_reset();
    bus.btn_up_n = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      exp_cmd = (c >= 7) ? 16'h0100 : 16'h0000;
      n_total++; if (bus.cmd_out !== exp_cmd) $display("FAIL single_cmd c=%0d got=%h exp=%h", c, bus.cmd_out, exp_cmd); else n_pass++;
      n_total++; if (bus.cmd_vld !== (c == 7)) $display("FAIL single_vld c=%0d got=%b exp=%b", c, bus.cmd_vld, (c == 7)); else n_pass++;
      n_total++; if (bus.up_held !== (c >= 6 && c <= 15)) $display("FAIL single_up_held c=%0d got=%b exp=%b", c, bus.up_held, (c >= 6 && c <= 15)); else n_pass++;
      if (c == 9) bus.btn_up_n = 1'b1;
    end
  endtask

  task automatic test_glitch();
    do_reset();
    bus.btn_dn_n = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_total++; if (bus.dn_held !== 1'b0) $display("FAIL glitch_dn_held c=%0d got=%b exp=0", c, bus.dn_held); else n_pass++;
      n_total++; if (bus.cmd_out !== 16'h0000 || bus.cmd_vld !== 1'b0)
        $display("FAIL glitch_cmd c=%0d got=%h/%b exp=0000/0", c, bus.cmd_out, bus.cmd_vld); else n_pass++;
      if (c == 2) bus.btn_dn_n = 1'b1;
    end
  endtask

  task automatic test_repeat_sat();
    logic [15:0] exp_cmd;
    logic        exp_vld;
    do_reset();
    bus.btn_up_n = 1'b0;
    for (int c = 0; c < 75; c++) begin
      tick();
      exp_cmd = (c < 7) ? 16'h0000 : (c < 27) ? 16'h0100 : (c < 32) ? 16'h0200 : 16'h0300;
      exp_vld = (c == 7 || c == 27 || c == 32);
      n_total++; if (bus.cmd_out !== exp_cmd) $display("FAIL repeat_cmd c=%0d got=%h exp=%h", c, bus.cmd_out, exp_cmd); else n_pass++;
      n_total++; if (bus.cmd_vld !== exp_vld) $display("FAIL repeat_vld c=%0d got=%b exp=%b", c, bus.cmd_vld, exp_vld); else n_pass++;
      if (c == 59) bus.btn_up_n = 1'b1;
    end
    n_total++; if (bus.up_held !== 1'b0) $display("FAIL repeat_release got=%b exp=0", bus.up_held); else n_pass++;
  endtask

  // Continues from +LIMIT left by test_repeat_sat; the last tap hits -LIMIT again
  task automatic test_dn_taps();
    logic [15:0] tap_exp [7];
    logic [15:0] exp_cmd;
    logic        exp_vld;
    int          k, ph;
    tap_exp = '{16'h0200, 16'h0100, 16'h0000, 16'hFF00, 16'hFE00, 16'hFD00, 16'hFD00};
    bus.btn_dn_n = 1'b0;
    for (int c = 0; c < 140; c++) begin
      tick();
      k  = c / 20;
      ph = c % 20;
      exp_cmd = (ph >= 7) ? tap_exp[k] : ((k == 0) ? 16'h0300 : tap_exp[k-1]);
      exp_vld = (ph == 7) && (k < 6);
      n_total++; if (bus.cmd_out !== exp_cmd) $display("FAIL taps_cmd c=%0d got=%h exp=%h", c, bus.cmd_out, exp_cmd); else n_pass++;
      n_total++; if (bus.cmd_vld !== exp_vld) $display("FAIL taps_vld c=%0d got=%b exp=%b", c, bus.cmd_vld, exp_vld); else n_pass++;
      if (ph == 6) begin
        n_total++; if (bus.dn_held !== 1'b1) $display("FAIL taps_dn_held c=%0d got=%b exp=1", c, bus.dn_held); else n_pass++;
      end
      bus.btn_dn_n = (((c + 1) % 20) < 10) ? 1'b0 : 1'b1;
    end
    bus.btn_dn_n = 1'b1;
    repeat (10) tick();
  endtask

  task automatic test_zero_while_up();
    logic [15:0] exp_cmd;
    logic        exp_vld;
    do_reset();
    bus.btn_up_n = 1'b0;
    for (int c = 0; c < 46; c++) begin
      tick();
      exp_cmd = (c < 7)  ? 16'h0000 : (c < 27) ? 16'h0100 : (c < 30) ? 16'h0200 :
                (c < 32) ? 16'h0000 : (c < 37) ? 16'h0100 : (c < 42) ? 16'h0200 : 16'h0300;
      exp_vld = (c == 7 || c == 27 || c == 30 || c == 32 || c == 37 || c == 42);
      n_total++; if (bus.cmd_out !== exp_cmd) $display("FAIL zero_cmd c=%0d got=%h exp=%h", c, bus.cmd_out, exp_cmd); else n_pass++;
      n_total++; if (bus.cmd_vld !== exp_vld) $display("FAIL zero_vld c=%0d got=%b exp=%b", c, bus.cmd_vld, exp_vld); else n_pass++;
      if (c == 22) bus.btn_zero_n = 1'b0;
      if (c == 32) bus.btn_zero_n = 1'b1;
    end
    bus.btn_up_n = 1'b1;
    repeat (15) tick();
  endtask

  task automatic test_both_held();
    do_reset();
    bus.btn_up_n = 1'b0;
    bus.btn_dn_n = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      n_total++; if (bus.cmd_out !== 16'h0000 || bus.cmd_vld !== 1'b0)
        $display("FAIL both_cmd c=%0d got=%h/%b exp=0000/0", c, bus.cmd_out, bus.cmd_vld); else n_pass++;
      if (c == 6) begin
        n_total++; if ({bus.up_held, bus.dn_held} !== 2'b11)
          $display("FAIL both_held c=%0d got=%b exp=11", c, {bus.up_held, bus.dn_held}); else n_pass++;
      end
      if (c == 11) begin
        bus.btn_up_n = 1'b1;
        bus.btn_dn_n = 1'b1;
      end
    end
    repeat (10) tick();
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp_cmd;
    do_reset();
    bus.btn_up_n = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (c == 27) begin
        n_total++; if (bus.cmd_out !== 16'h0200) $display("FAIL mid_pre_cmd got=%h exp=0200", bus.cmd_out); else n_pass++;
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_total++; if (bus.cmd_out !== 16'h0000) $display("FAIL mid_rst_cmd got=%h exp=0000", bus.cmd_out); else n_pass++;
    n_total++; if (bus.up_held !== 1'b0) $display("FAIL mid_rst_up_held got=%b exp=0", bus.up_held); else n_pass++;
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      exp_cmd = (c >= 7) ? 16'h0100 : 16'h0000;
      n_total++; if (bus.cmd_out !== exp_cmd) $display("FAIL mid_cmd c=%0d got=%h exp=%h", c, bus.cmd_out, exp_cmd); else n_pass++;
      n_total++; if (bus.cmd_vld !== (c == 7)) $display("FAIL mid_vld c=%0d got=%b exp=%b", c, bus.cmd_vld, (c == 7)); else n_pass++;
      n_total++; if (bus.up_held !== (c >= 6)) $display("FAIL mid_up_held c=%0d got=%b exp=%b", c, bus.up_held, (c >= 6)); else n_pass++;
    end
    bus.btn_up_n = 1'b1;
    repeat (10) tick();
  endtask

  initial begin
    bus.btn_up_n = 1'b1;
    bus.btn_dn_n = 1'b1;
    bus.btn_zero_n = 1'b1;
    test_reset();
    test_single_press();
    test_glitch();
    test_repeat_sat();
    test_dn_taps();
    test_zero_while_up();
    test_both_held();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
